// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, defaults and parity helper
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;
    localparam int PARITY_W       = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    // Callers zero-extend narrower words; zeros do not change the XOR.
    function automatic logic calc_parity(input logic [PARITY_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// rtl/uart_rx_oversample_if.sv - received-byte holding register handshake
interface uart_rx_oversample_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_error;
    logic                 frame_error;

    modport master (
        output rx_data, rx_valid, parity_error, frame_error,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_error, frame_error,
        output rx_ready
    );
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with selectable reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 16x oversampling UART receiver with one-entry holding register
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic                  rx_enable,
    input  logic                  rx_serial,
    uart_rx_oversample_if.master  rx,
    output logic                  overrun_error,
    output logic                  break_detect,
    output logic                  rx_active
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] MID_LO    = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] MID       = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] MID_HI    = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    rx_state_e            state, next_state;
    logic                 rxs;
    logic [CNT_W-1:0]     tick_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 samp_a, samp_b, vote;
    logic                 par_bit, par_flag, frame_flag;
    logic                 vote_pt, bit_end, frame_now, is_break, commit, accept;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_serial),
        .q   (rxs)
    );

    assign vote   = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign accept = rx.rx_valid && rx.rx_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!rx_enable) begin
            next_state = IDLE;
        end else if (sample_tick) begin
            case (state)
                IDLE:      if (!rxs) next_state = START;
                START:     if (vote_pt && vote) next_state = IDLE;
                           else if (bit_end)   next_state = DATA;
                DATA:      if (bit_end && bit_idx == DATA_LAST)
                               next_state = (PARITY_EN != 0) ? PARITY : STOP;
                PARITY:    if (bit_end) next_state = STOP;
                // Leave mid-bit so the next start edge is seen on time.
                STOP:      if (vote_pt && bit_idx == STOP_LAST)
                               next_state = is_break ? WAIT_IDLE : IDLE;
                WAIT_IDLE: if (rxs) next_state = IDLE;
                default:   next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        vote_pt   = sample_tick && (tick_cnt == MID_HI);
        bit_end   = sample_tick && (tick_cnt == CNT_LAST);
        frame_now = frame_flag | ~vote;
        is_break  = (shift == '0) && !par_bit && frame_now;
        commit    = rx_enable && (state == STOP) && vote_pt && (bit_idx == STOP_LAST);
        rx_active = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '1;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            par_bit    <= 1'b0;
            par_flag   <= 1'b0;
            frame_flag <= 1'b0;
        end else if (state == IDLE) begin
            tick_cnt   <= '0;
            bit_idx    <= '0;
            par_bit    <= 1'b0;
            par_flag   <= 1'b0;
            frame_flag <= 1'b0;
        end else if (sample_tick) begin
            tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CNT_W'(1);
            if (tick_cnt == MID_LO) samp_a <= rxs;
            if (tick_cnt == MID)    samp_b <= rxs;
            if (next_state != state)
                bit_idx <= '0;
            else if (bit_end && (state == DATA || state == STOP))
                bit_idx <= bit_idx + IDX_W'(1);
            if (vote_pt) begin
                case (state)
                    DATA:    shift <= {vote, shift[DATA_BITS-1:1]};
                    PARITY: begin
                        par_bit  <= vote;
                        par_flag <= vote ^ calc_parity(PARITY_W'(shift), 1'(PARITY_ODD));
                    end
                    STOP:    if (!vote) frame_flag <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx.rx_data      <= '0;
            rx.rx_valid     <= 1'b0;
            rx.parity_error <= 1'b0;
            rx.frame_error  <= 1'b0;
            overrun_error   <= 1'b0;
            break_detect    <= 1'b0;
        end else begin
            break_detect <= commit && is_break;
            if (commit) begin
                rx.rx_data      <= shift;
                rx.rx_valid     <= 1'b1;
                rx.parity_error <= par_flag;
                rx.frame_error  <= frame_now;
            end else if (accept) begin
                rx.rx_valid     <= 1'b0;
                rx.parity_error <= 1'b0;
                rx.frame_error  <= 1'b0;
            end
            if (commit && rx.rx_valid && !rx.rx_ready)
                overrun_error <= 1'b1;
            else if (accept)
                overrun_error <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - self-checking bench for uart_rx_oversample
module tb_uart_rx_oversample;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic clk, rst, sample_tick, rx_enable, rx_serial;
    logic overrun_error, break_detect, rx_active;
    int   cyc, checks, errors, brk_count;
    logic valid_before, valid_after;
    logic m_valid, m_ovr;
    int   m_brk;

    uart_rx_oversample_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_oversample #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (8),
        .PARITY_EN  (1),
        .PARITY_ODD (0),
        .STOP_BITS  (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_tick   (sample_tick),
        .rx_enable     (rx_enable),
        .rx_serial     (rx_serial),
        .rx            (rx_if),
        .overrun_error (overrun_error),
        .break_detect  (break_detect),
        .rx_active     (rx_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick lands on every posedge whose running count is a multiple of TICK_DIV.
    initial sample_tick = 1'b0;
    always @(negedge clk) sample_tick = (cyc % TICK_DIV == TICK_DIV - 1);

    initial brk_count = 0;
    always @(negedge clk) if (break_detect === 1'b1) brk_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_level(input logic level, input int n);
        repeat (n) begin
            @(negedge clk);
            rx_serial = level;
        end
    endtask

    // Start bit is launched right after a tick edge, so the final stop-bit vote
    // falls 2 sync clocks + 1 detect tick + 10 bits + (OS/2+1) ticks later.
    task automatic drive_frame(input logic [7:0] data, input logic pbit, input logic stop,
                               input bit acc_at_commit, input int cut_clks);
        logic [10:0] bits;
        int p0, commit_cyc, n_clks;
        bits = {stop, pbit, data, 1'b0};
        @(negedge clk);
        while (cyc % TICK_DIV != 0) @(negedge clk);
        p0 = cyc;
        commit_cyc = p0 + TICK_DIV * (2 + OS * 10 + OS / 2 + 1);
        n_clks = (cut_clks > 0) ? cut_clks : 11 * BIT_CLKS;
        for (int n = 0; n < n_clks; n++) begin
            if (n > 0) @(negedge clk);
            if (cyc == commit_cyc - 1) valid_before = rx_if.rx_valid;
            if (cyc == commit_cyc)     valid_after  = rx_if.rx_valid;
            rx_serial = bits[n / BIT_CLKS];
            rx_if.rx_ready = acc_at_commit && (cyc == commit_cyc - 1);
        end
        if (cut_clks == 0) begin
            rx_if.rx_ready = 1'b0;
            drive_level(1'b1, 2 * BIT_CLKS);
        end
    endtask

    task automatic accept_byte();
        @(negedge clk);
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic pe,
                               input logic fe, input logic ovr);
        check({tag, "_data"},   rx_if.rx_data,      d);
        check({tag, "_valid"},  rx_if.rx_valid,     1);
        check({tag, "_perr"},   rx_if.parity_error, pe);
        check({tag, "_ferr"},   rx_if.frame_error,  fe);
        check({tag, "_ovr"},    overrun_error,      ovr);
        check({tag, "_active"}, rx_active,          0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        rx_enable = 1'b1;
        rx_serial = 1'b1;
        rx_if.rx_ready = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data",   rx_if.rx_data,      0);
        check("rst_valid",  rx_if.rx_valid,     0);
        check("rst_perr",   rx_if.parity_error, 0);
        check("rst_ferr",   rx_if.frame_error,  0);
        check("rst_ovr",    overrun_error,      0);
        check("rst_brk",    break_detect,       0);
        check("rst_active", rx_active,          0);
        drive_level(1'b1, BIT_CLKS);

        drive_frame(8'hA5, 1'b0, 1'b1, 0, 0);
        check("a5_lat_before", valid_before, 0);
        check("a5_lat_after",  valid_after,  1);
        check_frame("a5", 8'hA5, 0, 0, 0);
        accept_byte();
        check("a5_accept_valid", rx_if.rx_valid, 0);

        drive_frame(8'h3C, 1'b1, 1'b1, 0, 0);
        check_frame("3c", 8'h3C, 1, 0, 0);
        accept_byte();
        check("3c_accept_perr", rx_if.parity_error, 0);

        drive_frame(8'h81, 1'b0, 1'b0, 0, 0);
        check_frame("81", 8'h81, 0, 1, 0);
        check("81_no_break", brk_count, 0);
        accept_byte();
        check("81_accept_ferr", rx_if.frame_error, 0);

        drive_level(1'b0, 5 * TICK_DIV);
        check("glitch_active", rx_active, 1);
        drive_level(1'b1, 2 * BIT_CLKS);
        check("glitch_idle",  rx_active,      0);
        check("glitch_valid", rx_if.rx_valid, 0);
        drive_frame(8'h55, 1'b0, 1'b1, 0, 0);
        check_frame("55", 8'h55, 0, 0, 0);
        accept_byte();

        drive_frame(8'h11, 1'b0, 1'b1, 0, 0);
        drive_frame(8'h22, 1'b0, 1'b1, 0, 0);
        check_frame("ovr22", 8'h22, 0, 0, 1);
        accept_byte();
        check("ovr_clr_valid", rx_if.rx_valid, 0);
        check("ovr_clr_flag",  overrun_error,  0);
        drive_frame(8'h33, 1'b0, 1'b1, 0, 0);
        drive_frame(8'h44, 1'b0, 1'b1, 1, 0);
        check("same_clk_before", valid_before, 1);
        check_frame("same_clk44", 8'h44, 0, 0, 0);
        accept_byte();

        drive_level(1'b0, 22 * BIT_CLKS);
        check("brk_count", brk_count,          1);
        check("brk_data",  rx_if.rx_data,      0);
        check("brk_valid", rx_if.rx_valid,     1);
        check("brk_ferr",  rx_if.frame_error,  1);
        check("brk_perr",  rx_if.parity_error, 0);
        check("brk_wait",  rx_active,          1);
        drive_level(1'b1, 2 * BIT_CLKS);
        check("brk_released", rx_active, 0);
        check("brk_single",   brk_count, 1);
        accept_byte();
        drive_frame(8'hF0, 1'b0, 1'b1, 0, 0);
        check_frame("f0", 8'hF0, 0, 0, 0);

        drive_frame(8'h99, 1'b0, 1'b1, 0, 5 * BIT_CLKS + 16);
        @(negedge clk);
        rx_enable = 1'b0;
        @(negedge clk);
        check("dis_active", rx_active, 0);
        drive_level(1'b0, 6 * BIT_CLKS);
        drive_level(1'b1, 2 * BIT_CLKS);
        rx_enable = 1'b1;
        drive_level(1'b1, BIT_CLKS);
        check("dis_held_data",  rx_if.rx_data,  8'hF0);
        check("dis_held_valid", rx_if.rx_valid, 1);
        check("dis_active2",    rx_active,      0);

        drive_frame(8'h99, 1'b0, 1'b1, 0, 6 * BIT_CLKS);
        @(negedge clk);
        rst = 1'b1;
        drive_level(1'b1, 3);
        rst = 1'b0;
        drive_level(1'b1, 2 * BIT_CLKS);
        check("mrst_data",   rx_if.rx_data,      0);
        check("mrst_valid",  rx_if.rx_valid,     0);
        check("mrst_ferr",   rx_if.frame_error,  0);
        check("mrst_ovr",    overrun_error,      0);
        check("mrst_active", rx_active,          0);
        drive_frame(8'h42, 1'b0, 1'b1, 0, 0);
        check_frame("42", 8'h42, 0, 0, 0);
        accept_byte();

        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_brk   = brk_count;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic pb, st, exp_pe, exp_fe;
            d  = 8'($urandom);
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                accept_byte();
                if (m_valid) begin
                    m_valid = 1'b0;
                    m_ovr   = 1'b0;
                end
            end
            exp_pe = (pb != ^d);
            exp_fe = !st;
            if (d == 8'h00 && !pb && !st) m_brk++;
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            drive_frame(d, pb, st, 0, 0);
            check_frame($sformatf("rnd%0d", i), d, exp_pe, exp_fe, m_ovr);
            check($sformatf("rnd%0d_brk", i), brk_count, m_brk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
